// File: rtl/gf_pkg.sv
// Shared constants, state encoding and op-count/latency helpers for the GF(2^M) datapath.
// GF_INV_CHECK_EN adds the self-check multiply state and lengthens the op sequence by one.
package gf_pkg;

   localparam int GF_M = 8;
   localparam logic [7:0] GF_AES_POLY = 8'h1B;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SQR  = 3'd1,
      MUL  = 3'd2,
      FIN  = 3'd3
`ifdef GF_INV_CHECK_EN
      , CHK = 3'd4
`endif
   } gf_state_e;

   function automatic int gf_op_count(input int m);
`ifdef GF_INV_CHECK_EN
      return 2 * m - 2;
`else
      return 2 * m - 3;
`endif
   endfunction

   function automatic int gf_latency(input int m);
      return m * gf_op_count(m) + 1;
   endfunction

   localparam int GF_OPS = gf_op_count(GF_M);
   localparam int GF_LAT = gf_latency(GF_M);

endpackage

// File: rtl/gf_inv_seq_if.sv
// Start/done request bus of the GF inverter; master = requester, slave = inverter.
// check_err exists only when GF_INV_CHECK_EN is defined.
interface gf_inv_seq_if #(parameter int M = 8);
   logic         start;
   logic [M-1:0] a;
   logic [M-1:0] poly;
   logic         busy;
   logic         done;
   logic [M-1:0] inv;
   logic         zero_err;
`ifdef GF_INV_CHECK_EN
   logic         check_err;

   modport master (output start, a, poly, input busy, done, inv, zero_err, check_err);
   modport slave  (input start, a, poly, output busy, done, inv, zero_err, check_err);
`else
   modport master (output start, a, poly, input busy, done, inv, zero_err);
   modport slave  (input start, a, poly, output busy, done, inv, zero_err);
`endif
endinterface

// File: rtl/gf_mul_lsb_serial.sv
// Bit-serial LSB-first GF(2^M) multiplier: loads on go, result p valid M cycles later.
// p is presented combinationally during the last step so the next op can load on the same edge.
import gf_pkg::*;

module gf_mul_lsb_serial #(
   parameter int M = GF_M
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         go,
   input  logic [M-1:0] x,
   input  logic [M-1:0] y,
   input  logic [M-1:0] poly,
   output logic         busy,
   output logic         valid,
   output logic [M-1:0] p
);

   localparam int CW = (M > 1) ? $clog2(M) : 1;

   logic          run;
   logic [CW-1:0] cnt;
   logic [M-1:0]  xs, yb, acc, pq;

   assign busy  = run;
   assign valid = run && (cnt == CW'(M - 1));
   assign p     = acc ^ (yb[0] ? xs : '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run <= 1'b0;
         cnt <= '0;
         xs  <= '0;
         yb  <= '0;
         acc <= '0;
         pq  <= '0;
      end else if (go) begin
         run <= 1'b1;
         cnt <= '0;
         xs  <= x;
         yb  <= y;
         acc <= '0;
         pq  <= poly;
      end else if (run) begin
         acc <= p;
         xs  <= {xs[M-2:0], 1'b0} ^ (xs[M-1] ? pq : '0);
         yb  <= yb >> 1;
         cnt <= cnt + 1'b1;
         if (valid) run <= 1'b0;
      end
   end

endmodule

// File: rtl/gf_inv_seq.sv
// GF(2^M) inverter: a^(2^M-2) by square-and-multiply on one shared serial multiplier.
// GF_INV_CHECK_EN appends an r*a multiply and flags check_err if the product is not 1.
import gf_pkg::*;

module gf_inv_seq #(
   parameter int M = GF_M
) (
   input  logic          clk,
   input  logic          rst_n,
   gf_inv_seq_if.slave   bus
);

   localparam int CW = $clog2(M);

   gf_state_e     state, state_nxt;
   logic [CW-1:0] step;
   logic [M-1:0]  a_q, poly_q;
   logic          accept, fast;
   logic          mgo, mbusy, mvalid;
   logic [M-1:0]  mx, my, mpoly, mp;
`ifdef GF_INV_CHECK_EN
   logic [M-1:0]  r;
`endif

   // FIN already reports done with busy low, so it accepts a new start like IDLE.
   assign accept = bus.start && !mbusy && (state == IDLE || state == FIN);
   assign fast   = accept && (bus.a == '0);

   gf_mul_lsb_serial #(.M(M)) u_mul (
      .clk   (clk),
      .rst_n (rst_n),
      .go    (mgo),
      .x     (mx),
      .y     (my),
      .poly  (mpoly),
      .busy  (mbusy),
      .valid (mvalid),
      .p     (mp)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Each op's result feeds the next op on the edge it becomes valid, so ops run back to back.
   always_comb begin
      state_nxt = state;
      mgo       = 1'b0;
      mx        = mp;
      my        = mp;
      mpoly     = poly_q;
      case (state)
         IDLE, FIN: begin
            state_nxt = IDLE;
            if (accept && !fast) begin
               state_nxt = SQR;
               mgo       = 1'b1;
               mx        = bus.a;
               my        = bus.a;
               mpoly     = bus.poly;
            end
         end
         SQR: if (mvalid) begin
            if (step < CW'(M - 2)) begin
               state_nxt = MUL;
               mgo       = 1'b1;
               my        = a_q;
            end else begin
`ifdef GF_INV_CHECK_EN
               state_nxt = CHK;
               mgo       = 1'b1;
               my        = a_q;
`else
               state_nxt = FIN;
`endif
            end
         end
         MUL: if (mvalid) begin
            state_nxt = SQR;
            mgo       = 1'b1;
         end
`ifdef GF_INV_CHECK_EN
         CHK: if (mvalid) state_nxt = FIN;
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step         <= '0;
         a_q          <= '0;
         poly_q       <= '0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.inv      <= '0;
         bus.zero_err <= 1'b0;
`ifdef GF_INV_CHECK_EN
         r             <= '0;
         bus.check_err <= 1'b0;
`endif
      end else begin
         bus.done <= 1'b0;
         bus.busy <= !(state_nxt == IDLE || state_nxt == FIN);
         if (accept) begin
            a_q          <= bus.a;
            poly_q       <= bus.poly;
            step         <= '0;
            bus.zero_err <= fast;
`ifdef GF_INV_CHECK_EN
            r             <= bus.a;
            bus.check_err <= 1'b0;
`endif
            if (fast) begin
               bus.done <= 1'b1;
               bus.inv  <= '0;
            end
         end
         if (state == MUL && mvalid) step <= step + 1'b1;
`ifdef GF_INV_CHECK_EN
         if (state == SQR && mvalid) r <= mp;
`endif
         if (state != FIN && state_nxt == FIN) begin
            bus.done <= 1'b1;
`ifdef GF_INV_CHECK_EN
            bus.inv       <= r;
            bus.check_err <= (mp != M'(1));
`else
            bus.inv       <= mp;
`endif
         end
      end
   end

endmodule

// File: tb/tb_gf_inv_seq.sv
// Self-checking bench for gf_inv_seq (M=8): vector table, corner sequences, random sweep.
// Build with GF_INV_CHECK_EN defined to also cover check_err and the longer latency.
`timescale 1ns/1ps
module tb_gf_inv_seq;

   localparam int M = 8;
`ifdef GF_INV_CHECK_EN
   localparam int LAT = 113;
`else
   localparam int LAT = 105;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   gf_inv_seq_if #(.M(M)) bus ();

   gf_inv_seq #(.M(M)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int exp_t [0:255];
   int log_t [0:255];

   typedef struct {
      logic [7:0] a;
      logic [7:0] poly;
      logic [7:0] inv;
      bit         zero;
   } vec_t;

   vec_t tbl [7];

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // AES-field inverse through log/antilog tables built from generator 0x03.
   function automatic int ref_inv(input int av);
      if (av == 0) return 0;
      return exp_t[(255 - log_t[av]) % 255];
   endfunction

   task automatic launch(input logic [7:0] av, input logic [7:0] pv);
      bus.start = 1'b1;
      bus.a     = av;
      bus.poly  = pv;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   // Returns at the negedge of the done cycle; lat=0 if done never came.
   task automatic wait_done(input int glitch_cyc, input bit rnd, output int lat, output int busy_bad);
      lat = 0;
      busy_bad = 0;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         bus.start = 1'b0;
         if (bus.done === 1'b1) begin
            lat = c;
            break;
         end
         if (bus.busy !== 1'b1) busy_bad++;
         if (c == glitch_cyc) begin
            bus.start = 1'b1;
            bus.a     = 8'h02;
            bus.poly  = 8'($urandom);
         end
         if (rnd) begin
            bus.a    = 8'($urandom);
            bus.poly = 8'($urandom);
            if ($urandom_range(0, 7) == 0) bus.start = 1'b1;
         end
      end
   endtask

   task automatic check_result(input string name, input int lat, input int bb,
                               input int exp_inv, input bit exp_zero);
      chk({name, " latency"}, lat, exp_zero ? 1 : LAT);
      chk({name, " inv"}, int'(bus.inv), exp_inv);
      chk({name, " zero_err"}, int'(bus.zero_err), int'(exp_zero));
      chk({name, " busy cycles"}, bb, 0);
      chk({name, " busy at done"}, int'(bus.busy), 0);
`ifdef GF_INV_CHECK_EN
      chk({name, " check_err"}, int'(bus.check_err), 0);
`endif
   endtask

   initial begin
      int lat, bb, ndone, perm[255];
      bus.start = 1'b0;
      bus.a     = '0;
      bus.poly  = '0;

      exp_t[0] = 1;
      log_t[1] = 0;
      for (int i = 1; i < 255; i++) begin
         int x, xt;
         x  = exp_t[i-1];
         xt = ((x << 1) & 255) ^ (((x & 128) != 0) ? 'h1B : 0);
         exp_t[i] = x ^ xt;
         log_t[exp_t[i]] = i;
      end

      tbl[0] = '{8'h53, 8'h1B, 8'hCA, 1'b0};
      tbl[1] = '{8'h02, 8'h1B, 8'h8D, 1'b0};
      tbl[2] = '{8'h01, 8'h1B, 8'h01, 1'b0};
      tbl[3] = '{8'h03, 8'h1B, 8'hF6, 1'b0};
      tbl[4] = '{8'h02, 8'h1D, 8'h8E, 1'b0};
      tbl[5] = '{8'h00, 8'h1B, 8'h00, 1'b1};
      tbl[6] = '{8'h53, 8'h1B, 8'hCA, 1'b0};

      repeat (3) @(negedge clk);
      chk("reset outputs", int'({bus.busy, bus.done, bus.inv, bus.zero_err}), 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         launch(tbl[i].a, tbl[i].poly);
         wait_done(0, 1'b0, lat, bb);
         check_result($sformatf("vec%0d", i), lat, bb, int'(tbl[i].inv), tbl[i].zero);
      end

      launch(8'h53, 8'h1B);
      wait_done(40, 1'b0, lat, bb);
      check_result("ignored start", lat, bb, 'hCA, 1'b0);

      launch(8'h53, 8'h1B);
      wait_done(0, 1'b0, lat, bb);
      check_result("b2b first", lat, bb, 'hCA, 1'b0);
      launch(8'h02, 8'h1B);
      wait_done(0, 1'b0, lat, bb);
      check_result("b2b second", lat, bb, 'h8D, 1'b0);

      launch(8'h53, 8'h1B);
      repeat (59) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid-op reset outputs", int'({bus.busy, bus.done, bus.inv, bus.zero_err}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      repeat (150) begin
         @(negedge clk);
         if (bus.done === 1'b1) ndone++;
      end
      chk("done after abort", ndone, 0);
      chk("busy after abort", int'(bus.busy), 0);
      launch(8'h53, 8'h1B);
      wait_done(0, 1'b0, lat, bb);
      check_result("after abort", lat, bb, 'hCA, 1'b0);

      for (int i = 0; i < 255; i++) perm[i] = i + 1;
      for (int i = 254; i > 0; i--) begin
         int j, t;
         j = $urandom_range(0, i);
         t = perm[i];
         perm[i] = perm[j];
         perm[j] = t;
      end
      for (int i = 0; i < 255; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         launch(8'(perm[i]), 8'h1B);
         wait_done(0, 1'b1, lat, bb);
         bus.start = 1'b0;
         chk($sformatf("sweep a=%0h inv", perm[i]), int'(bus.inv), ref_inv(perm[i]));
         chk($sformatf("sweep a=%0h latency", perm[i]), lat, LAT);
`ifdef GF_INV_CHECK_EN
         chk($sformatf("sweep a=%0h check_err", perm[i]), int'(bus.check_err), 0);
`endif
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
